// File: rtl/alu_pkg.sv
// Shared constants for the ALU op scheduler: FSM encoding, ALU in_sel controls and one-hot ops.
package alu_pkg;

   localparam int unsigned OPW = 7;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_WAIT = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   localparam logic [2:0] SEL_PERSIST = 3'b100;
   localparam logic [2:0] SEL_LOAD    = 3'b010;
   localparam logic [2:0] SEL_RESET   = 3'b001;

   localparam logic [OPW-1:0] OP_ADD = 7'b0000001;
   localparam logic [OPW-1:0] OP_SUB = 7'b0000010;
   localparam logic [OPW-1:0] OP_AND = 7'b0000100;
   localparam logic [OPW-1:0] OP_OR  = 7'b0001000;
   localparam logic [OPW-1:0] OP_XOR = 7'b0010000;
   localparam logic [OPW-1:0] OP_NOT = 7'b0100000;
   localparam logic [OPW-1:0] OP_SHL = 7'b1000000;

   // ALU control for the cycle spent in a given state; only LOAD pulses the load strobe.
   function automatic logic [2:0] in_sel_for(input logic [1:0] st);
      return (st == ST_LOAD) ? SEL_LOAD : SEL_PERSIST;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grants are combinational, the last winner is registered.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic grant0,
   output logic grant1
);

   logic last_grant_q;
   logic pick1;

   // With both valid the requester that did not win last time goes next.
   always_comb begin
      pick1  = valid1 && (!valid0 || !last_grant_q);
      grant1 = en && pick1;
      grant0 = en && valid0 && !pick1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if (grant1) begin
         last_grant_q <= 1'b1;
      end else if (grant0) begin
         last_grant_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: arbitrates, drives load/persist, returns tagged results.
module alu_op_scheduler #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned OPW     = 7,
   parameter int unsigned ALU_LAT = 1   // legal range 1..7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             on,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic [2:0]       alu_in_sel,
   output logic [WIDTH-1:0] alu_num1,
   output logic [WIDTH-1:0] alu_num2,
   output logic [OPW-1:0]   alu_out_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic [1:0]       state
);

   import alu_pkg::*;

   localparam logic [2:0] CNT_LAST = 3'(ALU_LAT - 1);

   function automatic logic is_onehot(input logic [OPW-1:0] v);
      return (v != '0) && ((v & (v - OPW'(1))) == '0);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [2:0]       in_sel_q;
   logic [WIDTH-1:0] num1_q, num2_q;
   logic [OPW-1:0]   out_sel_q;
   logic             rsp_valid_q, rsp_id_q, rsp_err_q;
   logic [WIDTH-1:0] rsp_data_q;

   logic             grant_en;
   logic             hs;
   logic             sel1;
   logic             op_ok;
   logic             wait_last;
   logic             rsp_accept;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [OPW-1:0]   sel_op;

   assign grant_en = (state_q == ST_IDLE) && on;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (grant_en),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .grant0 (req0_ready),
      .grant1 (req1_ready)
   );

   always_comb begin
      sel1       = req1_ready;
      hs         = req0_ready || req1_ready;
      sel_a      = sel1 ? req1_a  : req0_a;
      sel_b      = sel1 ? req1_b  : req0_b;
      sel_op     = sel1 ? req1_op : req0_op;
      op_ok      = is_onehot(sel_op);
      wait_last  = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
      rsp_accept = (state_q == ST_DONE) && rsp_ready;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               state_d = op_ok ? ST_LOAD : ST_DONE;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT;
            cnt_d   = 3'd0;
         end
         ST_WAIT: begin
            if (wait_last) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         in_sel_q    <= SEL_RESET;
         num1_q      <= '0;
         num2_q      <= '0;
         out_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in_sel_q <= in_sel_for(state_d);
         // Operands are loaded at the handshake so they are already stable during LOAD.
         if (hs && op_ok) begin
            num1_q    <= sel_a;
            num2_q    <= sel_b;
            out_sel_q <= sel_op;
         end
         if (hs) begin
            rsp_id_q  <= sel1;
            rsp_err_q <= !op_ok;
            if (!op_ok) begin
               rsp_data_q  <= '0;
               rsp_valid_q <= 1'b1;
            end
         end
         if (wait_last) begin
            rsp_data_q  <= alu_out;
            rsp_valid_q <= 1'b1;
         end
         if (rsp_accept) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign alu_in_sel  = in_sel_q;
   assign alu_num1    = num1_q;
   assign alu_num2    = num2_q;
   assign alu_out_sel = out_sel_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign state       = state_q;

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Controller that shares the single 8-bit ALU datapath between two requesters. It arbitrates round-robin, sequences the ALU through its reset/load/persist controls, waits the fixed ALU latency, and returns the tagged result over a valid/ready response port. It sits between the requester blocks and the ALU top and owns the ALU's in_sel, num1, num2 and out_sel.

Parameters:
WIDTH, 8, operand/result width
OPW, 7, one-hot operation select width (ALU out_sel)
ALU_LAT, 1, cycles from load to a valid ALU out (legal range 1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
on  in  1  enable; 0 blocks new grants, in-flight ops complete
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_op  in  OPW  requester 0 one-hot op
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
alu_in_sel  out  3  ALU control {persist, load, reset}
alu_num1, alu_num2  out  WIDTH  ALU operands
alu_out_sel  out  OPW  ALU op select
alu_out  in  WIDTH  ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester index of the response
rsp_data  out  WIDTH  result (0 on error)
rsp_err  out  1  op was not one-hot
state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; alu_in_sel=3'b001 for the reset cycle, 3'b100 afterwards.
  - alu_num1, alu_num2, alu_out_sel, rsp_* all 0; last_grant=1, so req0 wins first.
  - A reset mid-operation aborts the op with no response.
- States (2-bit encoding): IDLE=00, LOAD=01, WAIT=10, DONE=11.
- IDLE:
  - Grant goes to the valid requester that is not last_grant; a single valid requester is always granted.
  - reqN_ready=1 combinationally only when state==IDLE, on==1 and N is granted. At most one ready per cycle.
  - On handshake: capture a, b, op and id, then update last_grant.
  - Next state is LOAD if op is one-hot, else DONE with rsp_err=1.
- LOAD (exactly 1 cycle): alu_in_sel=3'b010; drive alu_num1/num2/out_sel from captured values; WAIT follows.
- WAIT:
  - alu_in_sel=3'b100 (persist); operands are held.
  - Counter runs ALU_LAT cycles. On the last WAIT cycle, register alu_out into rsp_data, then go to DONE.
- DONE:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the accept edge: rsp_valid drops and the FSM goes to IDLE. No new grant is issued in the same cycle.
- Latency: handshake at edge T, rsp_valid high from edge T+2+ALU_LAT. Error ops: rsp_valid from edge T+1.
- Throughput: one op per 3+ALU_LAT cycles, plus response backpressure.
- Outside LOAD/WAIT, alu_in_sel=3'b100 and the ALU operand outputs hold their last values.
- on deasserted mid-op: the op finishes normally; no grant until on=1.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1.
- Requester dropping valid before ready: legal; no capture occurs.

Decomposition:
- Shared package alu_pkg:
  - FSM state localparams.
  - in_sel constants: SEL_PERSIST=3'b100, SEL_LOAD=3'b010, SEL_RESET=3'b001.
  - OPW and the one-hot op constants: OP_ADD=7'b0000001, OP_SUB=7'b0000010, OP_AND=7'b0000100, OP_OR=7'b0001000, OP_XOR=7'b0010000, OP_NOT=7'b0100000, OP_SHL=7'b1000000.
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant plus last_grant register.

Test Plan:
- Basic, serialized timing: rst 2 cycles, then req0 a=8'h57 b=8'h1A op=OP_ADD, ALU_LAT=1 bench ALU model → alu_in_sel=010 exactly one cycle with num1=57/num2=1A; rsp_valid 3 cycles after handshake; rsp_id=0, rsp_data=8'h71, rsp_err=0.
- Round-robin, back-to-back: both requesters held valid with req0 SUB 05,03 and req1 AND F0,3C; rsp_ready=1 → responses in order id0=8'h02, id1=8'h30, id0, id1. ready is never high on both requesters in one cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_data and rsp_id stable, both ready=0. Release → single accept, then IDLE.
- Illegal op: req1 op=7'b0000011 → no LOAD cycle (alu_in_sel never 010); rsp_err=1, rsp_data=0, rsp_id=1 one cycle after handshake.
- on/reset interaction:
  - on=0 with req0 valid → req0_ready stays 0 for 10 cycles; on=1 → granted.
  - rst asserted during WAIT → state=00 and alu_in_sel=001 next cycle; no rsp_valid ever.
